// File: rtl/syn_trap_ctrl_pkg.sv
// Shared constants for the error-trapping sequencer: syndrome width,
// correction capability, FSM state encodings and shift-counter width.
package syn_trap_ctrl_pkg;

    localparam int SYN_W = 36;   // syndrome / shift register width
    localparam int T_MAX = 6;    // largest trappable error weight
    localparam int CNT_W = 6;    // shift counter width, covers MAX_SHIFT up to 64

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CHECK = 1'b1;

endpackage

// File: rtl/syn_trap_ctrl_weight6.sv
// Weight checker: flags a syndrome register whose Hamming weight is at most
// T_MAX. Purely combinational so the trap decision lands in the same cycle
// as the register value it looks at.
module weight6
    import syn_trap_ctrl_pkg::*;
(
    input  logic [SYN_W-1:0] vec,
    output logic             le_t
);

    logic [5:0] weight;

    // Population count of the register, then the threshold compare.
    always_comb begin
        weight = 6'd0;
        for (int i = 0; i < SYN_W; i++) begin
            weight = weight + 6'(vec[i]);
        end
        le_t = (weight <= 6'(T_MAX));
    end

endmodule

// File: rtl/syn_trap_ctrl.sv
// Error-trapping sequencer. Loads a syndrome, then each cycle either traps
// it (weight <= T_MAX), gives up after MAX_SHIFT positions, or shifts it once
// through the generator-polynomial feedback register.
//
// Handshake: start is a request sampled only while busy is low (IDLE); the
// edge that samples start=1 captures syn_in and raises busy. A request seen
// while busy is dropped, never queued. done is a one-cycle pulse that ends a
// search; found/shift_cnt/pattern are valid from done until the next accepted
// start. Because the state is already IDLE during the done cycle, a request
// held at that point is accepted with no idle gap.
module syn_trap_ctrl
    import syn_trap_ctrl_pkg::*;
#(
    parameter logic [SYN_W-1:0] GPOLY     = 36'h0_0000_0001,
    parameter int               MAX_SHIFT = 36
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [SYN_W-1:0] syn_in,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [CNT_W-1:0] shift_cnt,
    output logic [SYN_W-1:0] pattern
);

    logic [0:0]       state;
    logic [SYN_W-1:0] sreg;
    logic [SYN_W-1:0] sreg_next;
    logic [CNT_W-1:0] cnt;
    logic             wflag;
    logic             last_shift;

    weight6 u_weight6 (
        .vec  (sreg),
        .le_t (wflag)
    );

    // busy mirrors the FSM state directly, so it also serves as state visibility.
    assign busy = (state == ST_CHECK);

    // One shift step: multiply by x modulo g(x), with x^36 implied in g.
    always_comb begin
        sreg_next  = {sreg[SYN_W-2:0], 1'b0} ^ (sreg[SYN_W-1] ? GPOLY : '0);
        last_shift = (cnt == CNT_W'(MAX_SHIFT - 1));
    end

    // FSM, shifter, counter and result registers. The terminal-count test
    // sits ahead of the increment, so cnt never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            done      <= 1'b0;
            found     <= 1'b0;
            shift_cnt <= '0;
            pattern   <= '0;
            sreg      <= '0;
            cnt       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sreg  <= syn_in;
                        cnt   <= '0;
                        found <= 1'b0;
                        state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (wflag) begin
                        found     <= 1'b1;
                        pattern   <= sreg;
                        shift_cnt <= cnt;
                        done      <= 1'b1;
                        state     <= ST_IDLE;
                    end else if (last_shift) begin
                        found     <= 1'b0;
                        pattern   <= '0;
                        shift_cnt <= cnt;
                        done      <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        sreg <= sreg_next;
                        cnt  <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/syn_trap_ctrl.md
# syn_trap_ctrl

Error-trapping sequencer for the QR decoder's correction stage. It loads a 36-bit syndrome and clocks it through a syndrome shift register that carries generator-polynomial feedback. Each cycle it checks the register's Hamming weight against the t = 6 limit using the existing `weight6` checker. It reports the shift count and the trapped error pattern at the first shift where the weight is ≤ 6, or a failure after a full cycle of shifts.

## Interface
- `GPOLY`, default `36'h0_0000_0001`: low 36 coefficients of the degree-36 generator g(x), x^36 implied. The default makes the shift a pure rotation; the top level overrides it with the code's generator.
- `MAX_SHIFT`, default `36`: number of shift positions examined, range 1..64.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `start`  in  1: request. Sampled only in IDLE.
- `syn_in`  in  36: syndrome. Captured on the accepted `start` edge.
- `busy`  out  1: high while in CHECK.
- `done`  out  1: one-cycle pulse marking the end of a search.
- `found`  out  1: valid from `done` until the next accepted `start`. 1 = trapped.
- `shift_cnt`  out  6: shift index at which the search ended.
- `pattern`  out  36: trapped error pattern. All zeros on failure.

## Operation
- States: IDLE and CHECK, 1-bit encoding.
- IDLE with `start`=1: `sreg` ← `syn_in`, `cnt` ← 0, `found` ← 0, state ← CHECK. Other outputs hold.
- CHECK: `wflag` = `weight6(sreg)`, combinational. The first matching condition applies:
  - `wflag`=1: `found` ← 1, `pattern` ← `sreg`, `shift_cnt` ← `cnt`, `done` ← 1, state ← IDLE.
  - `cnt` = MAX_SHIFT−1: `found` ← 0, `pattern` ← 0, `shift_cnt` ← `cnt`, `done` ← 1, state ← IDLE.
  - otherwise: `sreg` ← {`sreg`[34:0], 1'b0} ^ (`sreg`[35] ? GPOLY : 0), `cnt` ← `cnt`+1.
- `start` while in CHECK is ignored; there is no queueing.
- `start` in the cycle `done` is high is accepted, because the state is already IDLE.
- `cnt` never wraps: the terminal check at MAX_SHIFT−1 precedes the increment.
- A zero syndrome traps at shift 0 with `pattern`=0 and `found`=1.
- `rst` at any point, including mid-search:
  - state ← IDLE;
  - `busy`, `done`, `found` ← 0;
  - `shift_cnt` ← 0, `pattern` ← 0, `sreg` ← 0, `cnt` ← 0.
  - An in-flight search is discarded with no `done`.

## Timing
- Reset values of all outputs are 0.
- Accept edge E0: `busy` is 1 from E0.
- Trap at shift k: `done`/`found`/`pattern`/`shift_cnt` are updated at edge E(k+1), and `busy` falls at the same edge.
- Failure: `done` at edge E(MAX_SHIFT) with `shift_cnt`=MAX_SHIFT−1.
- `done` is high for exactly one cycle. Result outputs are stable until the next accepted `start` or `rst`.
- Throughput: back-to-back searches are possible with zero idle cycles between `done` and the next accept.
- Critical path: `sreg` → `weight6` adder tree → compare → next-state logic, all in one cycle. No registered weight stage.

## Structure
- Shared header holds:
  - `SYN_W` = 36;
  - `T_MAX` = 6;
  - state encodings `ST_IDLE` and `ST_CHECK`;
  - the 6-bit counter width.
- One sub-module: `weight6`, instantiated unchanged on `sreg`.
- The feedback shifter and the FSM stay in this block.

## Test plan
- Zero syndrome:
  - Stimulus: `syn_in`=0, `start` at E0.
  - Required: `done` at E1; `found`=1, `shift_cnt`=0, `pattern`=0; `busy` high for exactly one cycle.
- Weight exactly 6:
  - Stimulus: `syn_in`=36'h0_0000_003F, default GPOLY.
  - Required: `found`=1, `shift_cnt`=0, `pattern`=36'h0_0000_003F at E1.
- Feedback trap:
  - Stimulus: GPOLY=36'h0_0000_00FF, `syn_in`=36'h8_0000_007F (weight 8).
  - Required: `done` at E2; `found`=1, `shift_cnt`=1, `pattern`=36'h0_0000_0001.
- Failure:
  - Stimulus: default GPOLY, `syn_in`=36'h0_0000_007F (weight 7, rotation preserves weight).
  - Required: `done` at E36; `found`=0, `shift_cnt`=35, `pattern`=0.
- Ignored and back-to-back starts:
  - Stimulus: `start` held high continuously during a failing search, then a zero-syndrome request.
  - Required: the first result is unaffected. The second search is accepted on the `done` cycle, and its `done` follows one edge later.
- Reset mid-search:
  - Stimulus: assert `rst` at E10 of a failing search.
  - Required: all outputs 0 next cycle, and no `done` pulse.
  - Follow-up: a new `start` then completes normally.
